// File: rtl/cpu_sram_bridge.sv
// Bridges the core's single-cycle inst/data SRAM ports onto one sram-like bus.
// The bus carries one transaction at a time. Data goes before fetch, and the pipeline stalls until results are held.
module cpu_sram_bridge #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              inst_sram_en,
    input  logic [ADDR_W-1:0] inst_sram_addr,
    output logic [DATA_W-1:0] inst_sram_rdata,

    input  logic              data_sram_en,
    input  logic [3:0]        data_sram_wen,
    input  logic [ADDR_W-1:0] data_sram_addr,
    input  logic [DATA_W-1:0] data_sram_wdata,
    output logic [DATA_W-1:0] data_sram_rdata,

    output logic              stallreq,

    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        D_REQ,
        D_WAIT,
        I_REQ,
        I_WAIT,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic              d_wr;
    logic [1:0]        d_size;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              i_pend;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] inst_hold;
    logic [DATA_W-1:0] data_hold;
    logic              busy;

    function automatic logic [1:0] wen_to_size(input logic [3:0] wen);
        logic [1:0] size;
        case (wen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size = 2'd0;
            4'b0011, 4'b1100:                   size = 2'd1;
            default:                            size = 2'd2;
        endcase
        return size;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            d_wr      <= 1'b0;
            d_size    <= '0;
            d_addr    <= '0;
            d_wdata   <= '0;
            i_pend    <= 1'b0;
            i_addr    <= '0;
            inst_hold <= '0;
            data_hold <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    i_pend <= inst_sram_en;
                    if (inst_sram_en) begin
                        i_addr <= inst_sram_addr;
                    end
                    if (data_sram_en) begin
                        d_wr    <= |data_sram_wen;
                        d_size  <= wen_to_size(data_sram_wen);
                        d_wdata <= data_sram_wdata;
                        // Reads go out as aligned words; the core picks its bytes from the held word
                        if (|data_sram_wen) begin
                            d_addr <= data_sram_addr;
                        end else begin
                            d_addr <= {data_sram_addr[ADDR_W-1:2], 2'b00};
                        end
                    end
                end
                D_WAIT: begin
                    if (bus_data_ok && !d_wr) begin
                        data_hold <= bus_rdata;
                    end
                end
                I_WAIT: begin
                    if (bus_data_ok) begin
                        inst_hold <= bus_rdata;
                        i_pend    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        bus_req   = 1'b0;
        bus_wr    = 1'b0;
        bus_size  = 2'd0;
        bus_addr  = '0;
        bus_wdata = '0;
        case (state)
            IDLE: begin
                busy = data_sram_en | inst_sram_en;
                if (data_sram_en) begin
                    state_nxt = D_REQ;
                end else if (inst_sram_en) begin
                    state_nxt = I_REQ;
                end
            end
            D_REQ: begin
                busy      = 1'b1;
                bus_req   = 1'b1;
                bus_wr    = d_wr;
                bus_size  = d_size;
                bus_addr  = d_addr;
                bus_wdata = d_wdata;
                if (bus_addr_ok) begin
                    state_nxt = D_WAIT;
                end
            end
            D_WAIT: begin
                busy = 1'b1;
                if (bus_data_ok) begin
                    state_nxt = i_pend ? I_REQ : DONE;
                end
            end
            I_REQ: begin
                busy     = 1'b1;
                bus_req  = 1'b1;
                bus_size = 2'd2;
                bus_addr = i_addr;
                if (bus_addr_ok) begin
                    state_nxt = I_WAIT;
                end
            end
            I_WAIT: begin
                busy = 1'b1;
                if (bus_data_ok) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // IDLE stall follows the enables combinationally, so mask it while reset is held
    assign stallreq        = busy & rst;
    assign inst_sram_rdata = inst_hold;
    assign data_sram_rdata = data_hold;

endmodule

// File: tb/tb_cpu_sram_bridge.sv
// Self-checking bench for cpu_sram_bridge: a core-side driver, a delay-programmable bus slave,
// and a scoreboard of expected bus requests that the slave checks against each cycle.
module tb_cpu_sram_bridge;

    logic        clk;
    logic        rst;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        stallreq;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    cpu_sram_bridge #(
        .ADDR_W(32),
        .DATA_W(32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_rdata (inst_sram_rdata),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .stallreq        (stallreq),
        .bus_req         (bus_req),
        .bus_wr          (bus_wr),
        .bus_size        (bus_size),
        .bus_addr        (bus_addr),
        .bus_wdata       (bus_wdata),
        .bus_addr_ok     (bus_addr_ok),
        .bus_data_ok     (bus_data_ok),
        .bus_rdata       (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    req_t        exp_q[$];
    logic [31:0] rdata_q[$];
    int          checks = 0;
    int          errors = 0;
    int          addr_delay = 0;
    int          data_delay = 2;
    int          sl_phase = 0;
    int          sl_cnt = 0;
    bit          stray = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Slave: drives handshakes on the falling edge, checks each presented request against the scoreboard
    always @(negedge clk) begin
        req_t r;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        if (!rst) begin
            sl_phase = 0;
            sl_cnt   = 0;
            exp_q.delete();
            rdata_q.delete();
        end else if (stray) begin
            bus_data_ok = 1'b1;
            bus_rdata   = 32'hBAD0_BAD0;
            stray       = 1'b0;
        end else if (sl_phase == 0) begin
            if (bus_req) begin
                check_eq("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    r = exp_q[0];
                    check_eq("req_addr", bus_addr, r.addr);
                    check_eq("req_wr", 32'(bus_wr), 32'(r.wr));
                    check_eq("req_size", 32'(bus_size), 32'(r.size));
                    if (r.wr) check_eq("req_wdata", bus_wdata, r.wdata);
                    if (sl_cnt == addr_delay) begin
                        bus_addr_ok = 1'b1;
                        void'(exp_q.pop_front());
                        sl_phase = 1;
                        sl_cnt   = 0;
                    end else begin
                        sl_cnt++;
                    end
                end
            end
        end else begin
            check_eq("wait_req_low", 32'(bus_req), 32'd0);
            sl_cnt++;
            if (sl_cnt == data_delay) begin
                bus_data_ok = 1'b1;
                bus_rdata   = (rdata_q.size() != 0) ? rdata_q.pop_front() : 32'hDEAD_0000;
                sl_phase    = 0;
                sl_cnt      = 0;
            end
        end
    end

    task automatic expect_req(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata);
        req_t r;
        r.wr = wr; r.size = size; r.addr = addr; r.wdata = wdata;
        exp_q.push_back(r);
        rdata_q.push_back(rdata);
    endtask

    task automatic drive_core(input logic d_en, input logic [3:0] wen, input logic [31:0] daddr,
                              input logic [31:0] wdata, input logic i_en, input logic [31:0] iaddr);
        data_sram_en    = d_en;
        data_sram_wen   = wen;
        data_sram_addr  = daddr;
        data_sram_wdata = wdata;
        inst_sram_en    = i_en;
        inst_sram_addr  = iaddr;
    endtask

    // Counts stalled cycles until the DONE cycle, where stallreq first drops
    task automatic run_txn(input string tag, input int exp_stall);
        int n;
        n = 0;
        #1;
        while (stallreq && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
    endtask

    task automatic end_txn();
        drive_core(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", checks, errors);
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        drive_core(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_bus_req", 32'(bus_req), 32'd0);
        check_eq("rst_stallreq", 32'(stallreq), 32'd0);
        check_eq("rst_bus_wr", 32'(bus_wr), 32'd0);
        check_eq("rst_bus_size", 32'(bus_size), 32'd0);
        check_eq("rst_bus_addr", bus_addr, 32'h0);
        check_eq("rst_inst_rdata", inst_sram_rdata, 32'h0);
        check_eq("rst_data_rdata", data_sram_rdata, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Fetch only
        addr_delay = 0; data_delay = 2;
        expect_req(1'b0, 2'd2, 32'hBFC0_0000, 32'h0, 32'h3C1D_0001);
        drive_core(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'hBFC0_0000);
        run_txn("fetch", 4);
        check_eq("fetch_inst_rdata", inst_sram_rdata, 32'h3C1D_0001);
        end_txn();

        // Load and fetch together: data first, single stall window
        expect_req(1'b0, 2'd2, 32'h8000_1004, 32'h0, 32'h1122_3344);
        expect_req(1'b0, 2'd2, 32'hBFC0_0004, 32'h0, 32'h5566_7788);
        drive_core(1'b1, 4'h0, 32'h8000_1004, 32'h0, 1'b1, 32'hBFC0_0004);
        run_txn("ld_fetch", 7);
        check_eq("ld_fetch_data_rdata", data_sram_rdata, 32'h1122_3344);
        check_eq("ld_fetch_inst_rdata", inst_sram_rdata, 32'h5566_7788);
        end_txn();

        // Byte, half and word stores leave the load holding register alone
        expect_req(1'b1, 2'd0, 32'h8000_0002, 32'h00AB_0000, 32'hDEAD_BEEF);
        drive_core(1'b1, 4'b0100, 32'h8000_0002, 32'h00AB_0000, 1'b0, 32'h0);
        run_txn("sb", 4);
        check_eq("sb_data_rdata", data_sram_rdata, 32'h1122_3344);
        end_txn();

        expect_req(1'b1, 2'd1, 32'h8000_0012, 32'h1234_0000, 32'hDEAD_BEEF);
        drive_core(1'b1, 4'b1100, 32'h8000_0012, 32'h1234_0000, 1'b0, 32'h0);
        run_txn("sh", 4);
        check_eq("sh_data_rdata", data_sram_rdata, 32'h1122_3344);
        end_txn();

        expect_req(1'b1, 2'd2, 32'h8000_0020, 32'hA5A5_A5A5, 32'hDEAD_BEEF);
        drive_core(1'b1, 4'b1111, 32'h8000_0020, 32'hA5A5_A5A5, 1'b0, 32'h0);
        run_txn("sw", 4);
        end_txn();

        // Sub-word read address goes out word-aligned
        expect_req(1'b0, 2'd2, 32'h8000_1004, 32'h0, 32'hCAFE_F00D);
        drive_core(1'b1, 4'h0, 32'h8000_1006, 32'h0, 1'b0, 32'h0);
        run_txn("lb_unaligned", 4);
        check_eq("lb_data_rdata", data_sram_rdata, 32'hCAFE_F00D);
        end_txn();

        // Backpressure: addr_ok withheld for 10 cycles, request checked stable every cycle
        addr_delay = 10;
        expect_req(1'b0, 2'd2, 32'hBFC0_0008, 32'h0, 32'h8FBF_0010);
        drive_core(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'hBFC0_0008);
        run_txn("backpressure", 14);
        check_eq("bp_inst_rdata", inst_sram_rdata, 32'h8FBF_0010);
        end_txn();
        addr_delay = 0;

        // Idle for 20 cycles
        for (int i = 0; i < 20; i++) begin
            check_eq("idle_bus_req", 32'(bus_req), 32'd0);
            check_eq("idle_stallreq", 32'(stallreq), 32'd0);
            @(posedge clk);
            #1;
        end
        check_eq("idle_inst_rdata", inst_sram_rdata, 32'h8FBF_0010);
        check_eq("idle_data_rdata", data_sram_rdata, 32'hCAFE_F00D);

        // Reset during D_WAIT, then a stray data_ok
        data_delay = 6;
        expect_req(1'b0, 2'd2, 32'h8000_2000, 32'h0, 32'h7777_7777);
        drive_core(1'b1, 4'h0, 32'h8000_2000, 32'h0, 1'b0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("abort_in_wait", 32'(sl_phase), 32'd1);
        rst = 1'b0;
        #1;
        check_eq("abort_bus_req", 32'(bus_req), 32'd0);
        check_eq("abort_stallreq", 32'(stallreq), 32'd0);
        check_eq("abort_data_rdata", data_sram_rdata, 32'h0);
        check_eq("abort_inst_rdata", inst_sram_rdata, 32'h0);
        drive_core(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        stray = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("stray_data_rdata", data_sram_rdata, 32'h0);
        check_eq("stray_bus_req", 32'(bus_req), 32'd0);
        check_eq("stray_stallreq", 32'(stallreq), 32'd0);

        // Normal fetch after the abort
        data_delay = 2;
        expect_req(1'b0, 2'd2, 32'hBFC0_0010, 32'h0, 32'h2408_0005);
        drive_core(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'hBFC0_0010);
        run_txn("recover", 4);
        check_eq("recover_inst_rdata", inst_sram_rdata, 32'h2408_0005);
        end_txn();
        repeat (2) @(posedge clk);
        #1;
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
